// File: rtl/paddle_pkg.sv
// Shared definitions for the paddle tracker: FSM states, coordinate width
// and the default geometry/motion parameters.
// Optional build macro used by paddle_tracker: PADDLE_STATUS_EN.
package paddle_pkg;

   localparam int COORD_W      = 10;

   localparam int SCREEN_H_DEF = 480;
   localparam int PADDLE_H_DEF = 64;
   localparam int PADDLE_W_DEF = 8;
   localparam int X_LEFT_DEF   = 16;
   localparam int STEP_DEF     = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SAMPLE = 2'd1,
      ST_MOVE   = 2'd2
   } state_t;

endpackage

// File: rtl/paddle_hit_detect.sv
// Purpose: combinational test of whether the scan pixel lies on the paddle.
// Latency: 0 cycles (pure compare; the parent registers the result).
// Backpressure: none.
module paddle_hit_detect
   import paddle_pkg::*;
#(
   parameter int PADDLE_H = PADDLE_H_DEF,
   parameter int PADDLE_W = PADDLE_W_DEF,
   parameter int X_LEFT   = X_LEFT_DEF
) (
   input  logic [COORD_W-1:0] pixel_x_i,
   input  logic [COORD_W-1:0] pixel_y_i,
   input  logic               pixel_valid_i,
   input  logic [COORD_W-1:0] paddle_y_i,
   output logic               hit_o
);

   // One extra bit so paddle_y + PADDLE_H cannot wrap near row 1023.
   logic [COORD_W:0] px, py, top, bot, xl, xr;

   // Widen coordinates and compute the paddle's bounding box.
   always_comb begin
      px    = {1'b0, pixel_x_i};
      py    = {1'b0, pixel_y_i};
      top   = {1'b0, paddle_y_i};
      bot   = top + (COORD_W+1)'(PADDLE_H);
      xl    = (COORD_W+1)'(X_LEFT);
      xr    = (COORD_W+1)'(X_LEFT + PADDLE_W);
      hit_o = pixel_valid_i && (px >= xl) && (px < xr) && (py >= top) && (py < bot);
   end

endmodule

// File: rtl/paddle_tracker.sv
// Purpose: once per frame moves the paddle top row toward the sampled target by at most STEP.
// Latency: paddle_y updates 3 cycles after frame_tick; paddle_hit is registered, 1 cycle.
// Backpressure: none; frame_tick while an update is in flight is dropped. Macro: PADDLE_STATUS_EN.
module paddle_tracker
   import paddle_pkg::*;
#(
   parameter int SCREEN_H = SCREEN_H_DEF,
   parameter int PADDLE_H = PADDLE_H_DEF,
   parameter int PADDLE_W = PADDLE_W_DEF,
   parameter int X_LEFT   = X_LEFT_DEF,
   parameter int STEP     = STEP_DEF
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [COORD_W-1:0] target_y,
   input  logic               frame_tick,
   input  logic [COORD_W-1:0] pixel_x,
   input  logic [COORD_W-1:0] pixel_y,
   input  logic               pixel_valid,
`ifdef PADDLE_STATUS_EN
   input  logic [1:0]         address,
   input  logic               chipselect,
   output logic [31:0]        readdata,
`endif
   output logic [COORD_W-1:0] paddle_y,
   output logic               paddle_hit,
   output logic               moving,
   output logic               at_target
);

   localparam int                   MAX_Y   = SCREEN_H - PADDLE_H;
   localparam logic [COORD_W-1:0]   MAX_Y_C = COORD_W'(MAX_Y);
   localparam logic [COORD_W-1:0]   HOME_C  = COORD_W'(MAX_Y / 2);
   localparam logic [COORD_W-1:0]   STEP_C  = COORD_W'(STEP);
   localparam logic signed [COORD_W:0] STEP_S = (COORD_W+1)'(STEP);

   state_t               state_q, state_d;
   logic [COORD_W-1:0]   paddle_y_q, paddle_y_d;
   logic [COORD_W-1:0]   tgt_q, tgt_d;
   logic                 moving_q, moving_d;
   logic                 hit_q, hit_d;
   logic signed [COORD_W:0] diff;

   paddle_hit_detect #(
      .PADDLE_H (PADDLE_H),
      .PADDLE_W (PADDLE_W),
      .X_LEFT   (X_LEFT)
   ) u_hit (
      .pixel_x_i     (pixel_x),
      .pixel_y_i     (pixel_y),
      .pixel_valid_i (pixel_valid),
      .paddle_y_i    (paddle_y_q),
      .hit_o         (hit_d)
   );

   // Next-state logic: tgt is clamped at SAMPLE, so stepping toward it keeps paddle_y in [0, MAX_Y].
   always_comb begin
      state_d    = state_q;
      paddle_y_d = paddle_y_q;
      tgt_d      = tgt_q;
      moving_d   = moving_q;
      diff       = $signed({1'b0, tgt_q}) - $signed({1'b0, paddle_y_q});
      case (state_q)
         ST_IDLE: begin
            if (frame_tick) state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            tgt_d   = (target_y > MAX_Y_C) ? MAX_Y_C : target_y;
            state_d = ST_MOVE;
         end
         ST_MOVE: begin
            if (diff > STEP_S) begin
               paddle_y_d = paddle_y_q + STEP_C;
               moving_d   = 1'b1;
            end else if (diff < -STEP_S) begin
               paddle_y_d = paddle_y_q - STEP_C;
               moving_d   = 1'b1;
            end else begin
               paddle_y_d = tgt_q;
               moving_d   = 1'b0;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset parks the paddle mid-screen and aborts any update.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         paddle_y_q <= HOME_C;
         tgt_q      <= HOME_C;
         moving_q   <= 1'b0;
         hit_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         paddle_y_q <= paddle_y_d;
         tgt_q      <= tgt_d;
         moving_q   <= moving_d;
         hit_q      <= hit_d;
      end
   end

   assign paddle_y   = paddle_y_q;
   assign paddle_hit = hit_q;
   assign moving     = moving_q;
   assign at_target  = (paddle_y_q == tgt_q);

`ifdef PADDLE_STATUS_EN
   // Zero-wait-state status read port.
   always_comb begin
      readdata = 32'd0;
      if (chipselect) begin
         case (address)
            2'd0:    readdata = {22'd0, paddle_y_q};
            2'd1:    readdata = {30'd0, at_target, moving_q};
            default: readdata = 32'd0;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_paddle_tracker.sv
// Directed bench for paddle_tracker: stimulus pushes expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_paddle_tracker;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [9:0] target_y = 10'd0;
   logic       frame_tick = 1'b0;
   logic [9:0] pixel_x = 10'd0;
   logic [9:0] pixel_y = 10'd0;
   logic       pixel_valid = 1'b0;
   logic [9:0] paddle_y;
   logic       paddle_hit, moving, at_target;
`ifdef PADDLE_STATUS_EN
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic [31:0] readdata;
`endif

   int checks = 0;
   int failures = 0;

   string q_name[$];
   int    q_kind[$];
   int    q_val[$];

   localparam int K_Y = 0, K_MOV = 1, K_AT = 2, K_HIT = 3, K_RD = 4;

   paddle_tracker dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .target_y    (target_y),
      .frame_tick  (frame_tick),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .pixel_valid (pixel_valid),
`ifdef PADDLE_STATUS_EN
      .address     (address),
      .chipselect  (chipselect),
      .readdata    (readdata),
`endif
      .paddle_y    (paddle_y),
      .paddle_hit  (paddle_hit),
      .moving      (moving),
      .at_target   (at_target)
   );

   always #5 clk = ~clk;

   // Monitor: every negedge, compare all pending expectations.
   always @(negedge clk) begin
      while (q_kind.size() > 0) begin
         string nm;
         int    k, ev, act;
         nm = q_name.pop_front();
         k  = q_kind.pop_front();
         ev = q_val.pop_front();
         case (k)
            K_Y:   act = int'(paddle_y);
            K_MOV: act = int'(moving);
            K_AT:  act = int'(at_target);
            K_HIT: act = int'(paddle_hit);
`ifdef PADDLE_STATUS_EN
            K_RD:  act = int'(readdata);
`endif
            default: act = -1;
         endcase
         checks++;
         if (act != ev) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, ev);
         end
      end
   end

   task automatic expect_v(input string nm, input int k, input int v);
      q_name.push_back(nm);
      q_kind.push_back(k);
      q_val.push_back(v);
   endtask

   task automatic expect_state(input string nm, input int y, input int mv, input int at);
      expect_v({nm, "_y"}, K_Y, y);
      expect_v({nm, "_moving"}, K_MOV, mv);
      expect_v({nm, "_at_target"}, K_AT, at);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full frame update: tick, SAMPLE, MOVE; returns just after MOVE.
   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      step();
   endtask

   task automatic do_reset();
      step();
      reset_n = 1'b0;
      #1;
      expect_state("reset", 208, 0, 1);
      expect_v("reset_hit", K_HIT, 0);
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   initial begin
      int y;
      int mv;
      do_reset();

      // Upward step limited to STEP.
      target_y = 10'd300;
      tick();
      expect_state("t300", 212, 1, 0);

      // Small move lands exactly on target.
      do_reset();
      target_y = 10'd210;
      tick();
      expect_state("t210", 210, 0, 1);

      // Out-of-range target saturates at MAX_Y.
      target_y = 10'd1023;
      y = 210;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (416 - y > 4) y = y + 4; else y = 416;
         expect_v($sformatf("sat_y_%0d", i), K_Y, y);
      end
      expect_state("sat_end", 416, 0, 1);

      // Move down to row 100 for hit tests.
      do_reset();
      target_y = 10'd100;
      y = 208;
      for (int i = 0; i < 27; i++) begin
         tick();
         if (y - 100 > 4) begin y = y - 4; mv = 1; end
         else begin y = 100; mv = 0; end
      end
      expect_state("down100", y, mv, 1);
      expect_v("down100_const", K_Y, 100);

      pixel_valid = 1'b1; pixel_x = 10'd16; pixel_y = 10'd100;
      step(); expect_v("hit_top_left", K_HIT, 1);
      pixel_x = 10'd23; pixel_y = 10'd163;
      step(); expect_v("hit_bot_right", K_HIT, 1);
      pixel_x = 10'd16; pixel_y = 10'd164;
      step(); expect_v("hit_below", K_HIT, 0);
      pixel_x = 10'd24; pixel_y = 10'd100;
      step(); expect_v("hit_right", K_HIT, 0);
      pixel_x = 10'd15;
      step(); expect_v("hit_left", K_HIT, 0);
      pixel_x = 10'd16; pixel_y = 10'd99;
      step(); expect_v("hit_above", K_HIT, 0);
      pixel_y = 10'd1023;
      step(); expect_v("hit_row1023", K_HIT, 0);
      pixel_y = 10'd120; pixel_valid = 1'b0;
      step(); expect_v("hit_invalid", K_HIT, 0);
      pixel_valid = 1'b1;
      step(); expect_v("hit_mid", K_HIT, 1);
      pixel_valid = 1'b0;

      // Back-to-back ticks: second one is dropped.
      target_y = 10'd0;
      frame_tick = 1'b1;
      step();
      step();
      frame_tick = 1'b0;
      step();
      expect_state("dbl_tick", 96, 1, 0);
      repeat (5) step();
      expect_v("dbl_tick_hold", K_Y, 96);

      // Reset during MOVE aborts the update.
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      reset_n = 1'b0;
      #1;
      expect_state("rst_move", 208, 0, 1);
      step();
      step();
      reset_n = 1'b1;
      step();
      expect_v("rst_move_hold", K_Y, 208);
      tick();
      expect_state("after_rst", 204, 1, 0);

      // target_y changes between ticks are ignored.
      target_y = 10'd416;
      repeat (4) step();
      expect_state("tgt_ignored", 204, 1, 0);

`ifdef PADDLE_STATUS_EN
      chipselect = 1'b1; address = 2'd0;
      #1; expect_v("rd_addr0", K_RD, 204);
      step();
      address = 2'd1;
      #1; expect_v("rd_addr1", K_RD, 1);
      step();
      address = 2'd2;
      #1; expect_v("rd_addr2", K_RD, 0);
      step();
      chipselect = 1'b0; address = 2'd0;
      #1; expect_v("rd_nocs", K_RD, 0);
`endif

      step();
      step();
      if (q_kind.size() != 0) begin
         failures++;
         $display("FAIL pending: got %0d expected 0", q_kind.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/paddle_tracker.md
PADDLE_TRACKER -- requirements
Module: paddle_tracker

Interface
REQ-001 SHALL have parameter SCREEN_H, default 480, visible display height in pixels.
REQ-002 SHALL have parameter PADDLE_H, default 64, paddle height in pixels.
REQ-003 SHALL have parameter PADDLE_W, default 8, paddle width in pixels.
REQ-004 SHALL have parameter X_LEFT, default 16, leftmost paddle pixel column.
REQ-005 SHALL have parameter STEP, default 4, maximum pixels moved per frame (1..63).
REQ-006 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-007 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-008 SHALL have port target_y  in  10  requested paddle top row, driven by the player Y PIO out_port.
REQ-009 SHALL have port frame_tick  in  1  one-cycle pulse at start of vertical blanking.
REQ-010 SHALL have ports pixel_x, pixel_y  in  10 each  current VGA scan coordinate.
REQ-011 SHALL have port pixel_valid  in  1  scan coordinate is inside the visible area.
REQ-012 SHALL have port paddle_y  out  10  current registered paddle top row.
REQ-013 SHALL have port paddle_hit  out  1  registered: scan pixel lies on the paddle.
REQ-014 SHALL have ports moving  out  1  and at_target  out  1  (status flags).

Function
REQ-015 SHALL define MAX_Y = SCREEN_H - PADDLE_H (416 at defaults).
REQ-016 SHALL implement FSM IDLE -> SAMPLE -> MOVE -> IDLE.
REQ-017 IDLE: on frame_tick=1 SHALL go to SAMPLE; otherwise stay.
REQ-018 SAMPLE: SHALL capture tgt = min(target_y, MAX_Y) into a register; next state MOVE.
REQ-019 MOVE: diff = tgt - paddle_y as 11-bit signed; |diff| <= STEP -> paddle_y <= tgt; diff > STEP -> paddle_y += STEP; diff < -STEP -> paddle_y -= STEP; next state IDLE.
REQ-020 paddle_y SHALL never leave [0, MAX_Y]; no wrap-around under any target value (e.g. 1023).
REQ-021 frame_tick asserted while in SAMPLE or MOVE SHALL be ignored (no queuing).
REQ-022 target_y changes between ticks SHALL have no effect until the next SAMPLE.
REQ-023 moving SHALL be 1 in the cycle after any MOVE that changed paddle_y by STEP (not reaching tgt), else 0; updated only on MOVE.
REQ-024 at_target SHALL be 1 when paddle_y == tgt register, evaluated combinationally from registers.
REQ-025 paddle_hit SHALL register pixel_valid && X_LEFT <= pixel_x < X_LEFT+PADDLE_W && paddle_y <= pixel_y < paddle_y+PADDLE_H; latency exactly 1 cycle.
REQ-026 Hit comparisons SHALL use 11-bit unsigned arithmetic to avoid overflow at row 1023.

Reset
REQ-027 reset_n=0 SHALL asynchronously force state IDLE, paddle_y = MAX_Y/2 (208), tgt = MAX_Y/2, moving=0, paddle_hit=0.
REQ-028 Reset asserted mid-SAMPLE/MOVE SHALL abort the update; first tick after release SHALL start a fresh SAMPLE.

Configuration
REQ-029 Macro PADDLE_STATUS_EN defined SHALL add Avalon slave ports address[1:0] in, chipselect in, readdata[31:0] out; readdata = {22'b0,paddle_y} at address 0, {30'b0,at_target,moving} at address 1, zero otherwise, combinational, zero wait states.
REQ-030 Macro PADDLE_STATUS_EN undefined SHALL omit those ports and all related logic; remaining behaviour identical.

Structure
REQ-031 Shared package paddle_pkg SHALL hold the FSM state enum, COORD_W=10 constant and default parameter values.
REQ-032 Hit comparison SHALL be a sub-module paddle_hit_detect (combinational compare, register in parent).

Verification
REQ-033 Reset, target_y=300, one tick -> paddle_y 208->212 after MOVE, moving=1, at_target=0.
REQ-034 target_y=210 from paddle_y=208, one tick -> paddle_y=210, moving=0, at_target=1.
REQ-035 target_y=1023 held, 60 ticks -> paddle_y saturates at 416, never exceeds it.
REQ-036 paddle_y=100, pixel_valid=1, pixel_x=16, pixel_y=100 -> paddle_hit=1 next cycle; pixel_y=164 or pixel_x=24 -> 0.
REQ-037 frame_tick pulses on two consecutive cycles -> exactly one STEP applied; reset_n pulsed during MOVE -> paddle_y=208.
REQ-038 With PADDLE_STATUS_EN, chipselect=1, address=0 -> readdata=paddle_y; address=1 -> {at_target,moving}; address=2 -> 0.
